// File: rtl/des_access_sequencer_pkg.sv
// des_ctrl_pkg: shared types and constants for the DES access sequencer.
//   des_seq_state_t     - sequencer FSM state encoding
//   DES_LATENCY_DEFAULT - core latency from the chip-select sample edge to valid cipher text
//   DES_BLOCK_W         - DES block width in bits
package des_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } des_seq_state_t;

  localparam int DES_LATENCY_DEFAULT = 18;
  localparam int DES_BLOCK_W         = 64;

endpackage

// File: rtl/des_access_sequencer_if.sv
// des_access_sequencer_if: requester, DES core and response signals of the sequencer.
//   master modport - the sequencer: takes requests and cipher text, drives grant,
//                    core pins and the response.
//   slave modport  - the requesters, core and response consumer around it.
// Signals:
//   REQ, REQ_TEXT, REQ_ADDR                     requester side (REQ_TEXT flat, 64 bits per requester)
//   GNT                                         one-hot grant pulse
//   DES_CS_BAR, DES_ADDRESS, DES_PLAIN_TEXT     core inputs
//   DES_CIPHER_TEXT                             core output
//   RSP_VALID, RSP_READY, RSP_ID, RSP_DATA      result handshake
//   BUSY                                        sequencer not idle
interface des_access_sequencer_if
  import des_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
);

  logic [NREQ-1:0]             REQ;
  logic [DES_BLOCK_W*NREQ-1:0] REQ_TEXT;
  logic [NREQ-1:0]             REQ_ADDR;
  logic [NREQ-1:0]             GNT;
  logic                        DES_CS_BAR;
  logic                        DES_ADDRESS;
  logic [DES_BLOCK_W-1:0]      DES_PLAIN_TEXT;
  logic [DES_BLOCK_W-1:0]      DES_CIPHER_TEXT;
  logic                        RSP_VALID;
  logic                        RSP_READY;
  logic [IDW-1:0]              RSP_ID;
  logic [DES_BLOCK_W-1:0]      RSP_DATA;
  logic                        BUSY;

  modport master (
    input  REQ, REQ_TEXT, REQ_ADDR, DES_CIPHER_TEXT, RSP_READY,
    output GNT, DES_CS_BAR, DES_ADDRESS, DES_PLAIN_TEXT,
           RSP_VALID, RSP_ID, RSP_DATA, BUSY
  );

  modport slave (
    output REQ, REQ_TEXT, REQ_ADDR, DES_CIPHER_TEXT, RSP_READY,
    input  GNT, DES_CS_BAR, DES_ADDRESS, DES_PLAIN_TEXT,
           RSP_VALID, RSP_ID, RSP_DATA, BUSY
  );

endinterface

// File: rtl/des_access_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req        - request vector
//   ptr        - highest-priority index this round
//   gnt_onehot - one-hot winner (zero when no request)
//   gnt_id     - winner index
//   any        - at least one request present
// Scans from ptr upward, wrapping at NREQ-1 -> 0, so non power-of-two NREQ
// never selects an out-of-range index.
module rr_arbiter
  import des_ctrl_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_id,
  output logic            any
);

  int             idx;
  logic [IDW-1:0] sel;

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    any        = 1'b0;
    idx        = 0;
    sel        = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      sel = idx[IDW-1:0];
      if (!any && req[sel]) begin
        any             = 1'b1;
        gnt_onehot[sel] = 1'b1;
        gnt_id          = sel;
      end
    end
  end

endmodule

// File: rtl/des_access_sequencer.sv
// des_access_sequencer: shares one DES core among NREQ requesters, round-robin.
// Ports:
//   CLK, RST_N - clock, asynchronous active-low reset
//   bus        - des_access_sequencer_if.master (requests, core pins, response)
// Per grant: latch the winner, pulse GNT and chip select for one cycle, wait
// DES_LATENCY cycles, capture the cipher text and hold it until RSP_READY.
// Every output comes straight from a register.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | arbitrate; on a winner latch text/addr/id and raise GNT + CS
// ST_LAUNCH | GNT and chip select low for this single cycle; clear lat_cnt
// ST_WAIT   | core busy; capture cipher text when lat_cnt hits DES_LATENCY-1
// ST_RESP   | RSP_VALID held until RSP_READY; then advance rr_ptr past id
module des_access_sequencer
  import des_ctrl_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int DES_LATENCY = DES_LATENCY_DEFAULT,
  parameter int IDW         = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  des_access_sequencer_if.master bus
);

  localparam int                CNT_W    = $clog2(DES_LATENCY + 1);
  localparam logic [CNT_W-1:0]  LAT_LAST = CNT_W'(DES_LATENCY - 1);
  localparam logic [IDW-1:0]    ID_LAST  = IDW'(NREQ - 1);

  des_seq_state_t         state;
  logic [CNT_W-1:0]       lat_cnt;
  logic [IDW-1:0]         rr_ptr;
  logic [IDW-1:0]         id_q;
  logic [NREQ-1:0]        gnt_q;
  logic                   cs_bar_q;
  logic                   addr_q;
  logic [DES_BLOCK_W-1:0] pt_q;
  logic                   rsp_valid_q;
  logic [DES_BLOCK_W-1:0] rsp_data_q;
  logic                   busy_q;

  logic [NREQ-1:0]        arb_onehot;
  logic [IDW-1:0]         arb_id;
  logic                   arb_any;
  logic [DES_BLOCK_W-1:0] sel_text;
  logic                   sel_addr;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req        (bus.REQ),
    .ptr        (rr_ptr),
    .gnt_onehot (arb_onehot),
    .gnt_id     (arb_id),
    .any        (arb_any)
  );

  // One-hot mux of the winner's plaintext and address bit.
  always_comb begin
    sel_text = '0;
    sel_addr = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_onehot[i]) begin
        sel_text = bus.REQ_TEXT[i*DES_BLOCK_W +: DES_BLOCK_W];
        sel_addr = bus.REQ_ADDR[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      lat_cnt     <= '0;
      rr_ptr      <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      cs_bar_q    <= 1'b1;
      addr_q      <= 1'b0;
      pt_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            id_q     <= arb_id;
            gnt_q    <= arb_onehot;
            cs_bar_q <= 1'b0;
            pt_q     <= sel_text;
            addr_q   <= sel_addr;
            busy_q   <= 1'b1;
            state    <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          gnt_q    <= '0;
          cs_bar_q <= 1'b1;
          lat_cnt  <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // Capture edge is DES_LATENCY edges after the core sampled CS low.
          if (lat_cnt == LAT_LAST) begin
            rsp_data_q  <= bus.DES_CIPHER_TEXT;
            rsp_valid_q <= 1'b1;
            state       <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.RSP_READY) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rr_ptr      <= (id_q == ID_LAST) ? '0 : id_q + 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.GNT            = gnt_q;
  assign bus.DES_CS_BAR     = cs_bar_q;
  assign bus.DES_ADDRESS    = addr_q;
  assign bus.DES_PLAIN_TEXT = pt_q;
  assign bus.RSP_VALID      = rsp_valid_q;
  assign bus.RSP_ID         = id_q;
  assign bus.RSP_DATA       = rsp_data_q;
  assign bus.BUSY           = busy_q;

endmodule

// File: tb/tb_des_access_sequencer.sv
// tb_des_access_sequencer: scoreboard bench for des_access_sequencer (NREQ=3).
// A behavioural DES core returns a keyed scramble of the plaintext for exactly
// one cycle, so an early or late capture shows up as a data error.
module tb_des_access_sequencer;
  import des_ctrl_pkg::*;

  localparam int NREQ = 3;
  localparam int LAT  = DES_LATENCY_DEFAULT;
  localparam int IDW  = $clog2(NREQ);
  localparam logic [63:0] GARB = 64'hDEAD_BEEF_0BAD_F00D;

  typedef struct {
    logic [NREQ-1:0] gnt;
    int              id;
    logic [63:0]     data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  des_access_sequencer_if #(.NREQ(NREQ), .IDW(IDW)) bus();

  des_access_sequencer #(
    .NREQ        (NREQ),
    .DES_LATENCY (LAT),
    .IDW         (IDW)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  logic [63:0]     txt [NREQ] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210, 64'h0F1E2D3C4B5A6978};
  logic [NREQ-1:0] addr_bits = 3'b010;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int gnt_cnt = 0;
  int rsp_cnt = 0;
  int cs_lows = 0;
  int last_gnt_cyc = 0;
  int model_ptr = 0;
  exp_t gnt_q[$];
  exp_t rsp_q[$];
  int   gnt_cyc[$];

  function automatic logic [63:0] core_f(input logic [63:0] pt, input logic a);
    return {pt[31:0], pt[63:32]} ^ (a ? 64'h5A5A_3C3C_9696_C3C3 : 64'h0F0F_F0F0_1234_8765);
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (p + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  // Behavioural DES core: cipher valid only in the cycle before the capture edge.
  logic [63:0] cipher;
  logic [63:0] core_pt;
  logic        core_a;
  logic        core_busy;
  int          core_cnt;
  assign bus.DES_CIPHER_TEXT = cipher;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cipher    <= GARB;
      core_pt   <= '0;
      core_a    <= 1'b0;
      core_busy <= 1'b0;
      core_cnt  <= 0;
    end else begin
      cipher <= GARB;
      if (!bus.DES_CS_BAR) begin
        core_busy <= 1'b1;
        core_cnt  <= 0;
        core_pt   <= bus.DES_PLAIN_TEXT;
        core_a    <= bus.DES_ADDRESS;
      end else if (core_busy) begin
        core_cnt <= core_cnt + 1;
        if (core_cnt + 1 == LAT - 1) begin
          cipher    <= core_f(core_pt, core_a);
          core_busy <= 1'b0;
        end
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input int id, input bit with_rsp);
    exp_t e;
    e.gnt = '0;
    e.gnt[id] = 1'b1;
    e.id = id;
    e.data = core_f(txt[id], addr_bits[id]);
    gnt_q.push_back(e);
    if (with_rsp) rsp_q.push_back(e);
  endtask

  task automatic wait_gnt(input int target, input string tag);
    for (int k = 0; k < 400 && gnt_cnt < target; k++) tick();
    check_eq(tag, 64'(gnt_cnt), 64'(target));
  endtask

  task automatic wait_rsp(input int target, input string tag);
    for (int k = 0; k < 400 && rsp_cnt < target; k++) tick();
    check_eq(tag, 64'(rsp_cnt), 64'(target));
  endtask

  // Queue n expected transactions from the model, hold req until the n-th
  // grant, then wait for all results; optionally check back-to-back spacing.
  task automatic do_burst(input logic [NREQ-1:0] req, input int n, input bit spacing);
    int sg, sr, id;
    sg = gnt_cnt;
    sr = rsp_cnt;
    for (int k = 0; k < n; k++) begin
      id = rr_pick(req, model_ptr);
      push_txn(id, 1'b1);
      model_ptr = (id + 1) % NREQ;
    end
    bus.REQ = req;
    wait_gnt(sg + n, "burst_gnt_count");
    bus.REQ = '0;
    wait_rsp(sr + n, "burst_rsp_count");
    if (spacing)
      for (int k = 1; k < n; k++)
        check_eq("b2b_spacing", 64'(gnt_cyc[sg+k] - gnt_cyc[sg+k-1]), 64'(LAT + 3));
  endtask

  task automatic monitor();
    exp_t e;
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (!bus.DES_CS_BAR) begin
        cs_lows++;
        check_eq("cs_with_gnt", 64'(bus.GNT != '0), 64'd1);
      end
      if (bus.GNT != '0) begin
        if (gnt_q.size() == 0) begin
          check_eq("gnt_spurious", 64'(bus.GNT), 64'd0);
        end else begin
          e = gnt_q.pop_front();
          check_eq("gnt_onehot", 64'(bus.GNT), 64'(e.gnt));
          check_eq("launch_text", bus.DES_PLAIN_TEXT, txt[e.id]);
          check_eq("launch_addr", 64'(bus.DES_ADDRESS), 64'(addr_bits[e.id]));
        end
        gnt_cnt++;
        gnt_cyc.push_back(cyc);
        last_gnt_cyc = cyc;
      end
      if (bus.RSP_VALID && !pv)
        check_eq("rsp_latency", 64'(cyc - last_gnt_cyc), 64'(LAT + 1));
      if (bus.RSP_VALID && bus.RSP_READY) begin
        if (rsp_q.size() == 0) begin
          check_eq("rsp_spurious", 64'(bus.RSP_VALID), 64'd0);
        end else begin
          e = rsp_q.pop_front();
          check_eq("rsp_id", 64'(bus.RSP_ID), 64'(e.id));
          check_eq("rsp_data", bus.RSP_DATA, e.data);
        end
        rsp_cnt++;
      end
      pv = bus.RSP_VALID;
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check_eq({pfx, "_gnt"},    64'(bus.GNT), 64'd0);
    check_eq({pfx, "_cs_bar"}, 64'(bus.DES_CS_BAR), 64'd1);
    check_eq({pfx, "_addr"},   64'(bus.DES_ADDRESS), 64'd0);
    check_eq({pfx, "_pt"},     bus.DES_PLAIN_TEXT, 64'd0);
    check_eq({pfx, "_valid"},  64'(bus.RSP_VALID), 64'd0);
    check_eq({pfx, "_id"},     64'(bus.RSP_ID), 64'd0);
    check_eq({pfx, "_data"},   bus.RSP_DATA, 64'd0);
    check_eq({pfx, "_busy"},   64'(bus.BUSY), 64'd0);
  endtask

  initial begin
    int sg, sr, cs0;
    logic [63:0] exp0;

    bus.REQ       = '0;
    bus.REQ_TEXT  = {txt[2], txt[1], txt[0]};
    bus.REQ_ADDR  = addr_bits;
    bus.RSP_READY = 1'b1;
    rst_n         = 1'b0;

    fork
      monitor();
      begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // Non-power-of-two wrap: 0,1,2,0 from ptr 0.
    do_burst(3'b111, 4, 1'b1);

    // Single request: one chip-select pulse per transaction.
    cs0 = cs_lows;
    do_burst(3'b001, 1, 1'b0);
    check_eq("single_cs_pulses", 64'(cs_lows - cs0), 64'd1);

    // Two-requester fairness, back-to-back with RSP_READY high.
    do_burst(3'b011, 4, 1'b1);

    // Withdrawn request: REQ[1] pulses during WAIT only.
    sg = gnt_cnt;
    sr = rsp_cnt;
    push_txn(0, 1'b1);
    model_ptr = 1;
    bus.REQ = 3'b001;
    wait_gnt(sg + 1, "wd_gnt");
    bus.REQ = '0;
    repeat (3) tick();
    bus.REQ = 3'b010;
    tick();
    bus.REQ = '0;
    wait_rsp(sr + 1, "wd_rsp");
    repeat (30) tick();
    check_eq("wd_no_extra_gnt", 64'(gnt_cnt), 64'(sg + 1));

    // Backpressure: requester 0 result held 10 cycles, requester 1 pending.
    sg = gnt_cnt;
    sr = rsp_cnt;
    push_txn(0, 1'b1);
    push_txn(1, 1'b1);
    model_ptr = 2;
    exp0 = core_f(txt[0], addr_bits[0]);
    bus.RSP_READY = 1'b0;
    bus.REQ = 3'b001;
    wait_gnt(sg + 1, "bp_gnt0");
    bus.REQ = 3'b010;
    for (int k = 0; k < 40 && !bus.RSP_VALID; k++) tick();
    check_eq("bp_valid_seen", 64'(bus.RSP_VALID), 64'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("bp_valid_hold", 64'(bus.RSP_VALID), 64'd1);
      check_eq("bp_busy",       64'(bus.BUSY), 64'd1);
      check_eq("bp_data_hold",  bus.RSP_DATA, exp0);
      check_eq("bp_id_hold",    64'(bus.RSP_ID), 64'd0);
      check_eq("bp_no_gnt",     64'(bus.GNT), 64'd0);
    end
    bus.RSP_READY = 1'b1;
    tick();
    check_eq("bp_valid_drop", 64'(bus.RSP_VALID), 64'd0);
    check_eq("bp_idle",       64'(bus.BUSY), 64'd0);
    check_eq("bp_one_rsp",    64'(rsp_cnt), 64'(sr + 1));
    wait_gnt(sg + 2, "bp_gnt1");
    bus.REQ = '0;
    wait_rsp(sr + 2, "bp_rsp1");

    // Mid-flight reset at WAIT cycle 5; rr_ptr was 2 before reset.
    sg = gnt_cnt;
    sr = rsp_cnt;
    push_txn(0, 1'b0);
    bus.REQ = 3'b001;
    wait_gnt(sg + 1, "rst_gnt");
    bus.REQ = '0;
    repeat (5) tick();
    check_eq("rst_busy_before", 64'(bus.BUSY), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    check_eq("rst_no_rsp", 64'(rsp_cnt), 64'(sr));
    model_ptr = 0;
    do_burst(3'b110, 1, 1'b0);
    repeat (5) tick();

    check_eq("queues_drained", 64'(gnt_q.size() + rsp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/des_access_sequencer.md
# des_access_sequencer

Round-robin controller that shares one DES encryption core among `NREQ` requesters. It sits between the requester ports (host command decoder, self-test engine, …) and the core's `CHIP_SELECT_BAR`/`ADDRESS`/`PLAIN_TEXT`/`CIPHER_TEXT` pins. Per granted request it launches one encryption, waits the fixed core latency, captures the cipher text and returns it with a valid/ready handshake. It replaces the ad-hoc busy/ready counting currently done around the core.

## Interface
- `NREQ`, default 2: number of requesters, range 2..8.
- `DES_LATENCY`, default 18: cycles from the chip-select sample edge to `CIPHER_TEXT` valid. Minimum 1.
- `IDW`, default `$clog2(NREQ)`: requester-id width.

Ports:
- `CLK` in 1: single clock. All logic is on the rising edge.
- `RST_N` in 1: asynchronous, active-low reset.
- `REQ` in NREQ: per-requester request level. Hold until `GNT`.
- `REQ_TEXT` in 64*NREQ: plaintext, flat; requester i uses bits [64i+63:64i].
- `REQ_ADDR` in NREQ: per-requester `ADDRESS` bit.
- `GNT` out NREQ: one-hot, one-cycle grant pulse.
- `DES_CS_BAR` out 1: core chip select, active low.
- `DES_ADDRESS` out 1: core address bit.
- `DES_PLAIN_TEXT` out 64: core plaintext.
- `DES_CIPHER_TEXT` in 64: core cipher text.
- `RSP_VALID` out 1: result valid.
- `RSP_READY` in 1: consumer accepts the result.
- `RSP_ID` out IDW: index of the requester that owns the result.
- `RSP_DATA` out 64: captured cipher text.
- `BUSY` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP. The state encoding is an enum in the package.
- **IDLE**
  - If `REQ` is non-zero, select the first set bit at or after `rr_ptr`, wrapping modulo NREQ.
  - Latch the winner's text, addr and id.
  - Go to LAUNCH.
  - If `REQ` is zero, stay in IDLE.
- **LAUNCH** (exactly 1 cycle)
  - `GNT[id]`=1.
  - `DES_CS_BAR`=0.
  - `DES_PLAIN_TEXT` and `DES_ADDRESS` are driven from the latched values.
  - Clear `lat_cnt`, go to WAIT.
- **WAIT**
  - `DES_CS_BAR`=1.
  - Plaintext and address stay stable from LAUNCH until the state leaves WAIT.
  - `lat_cnt` increments each cycle.
  - When `lat_cnt`==DES_LATENCY-1, capture `DES_CIPHER_TEXT` into `RSP_DATA` and go to RESP.
- **RESP**
  - `RSP_VALID`=1.
  - `RSP_DATA` and `RSP_ID` are held until `RSP_VALID & RSP_READY`.
  - On the handshake: `rr_ptr` ← (id+1) mod NREQ, go to IDLE.
- Counter and pointer widths:
  - `lat_cnt` is `$clog2(DES_LATENCY+1)` bits and never wraps.
  - `rr_ptr` is IDW bits; wrap explicitly at NREQ-1 → 0, also when NREQ is not a power of two.
- Boundary rules:
  - `REQ` changes during LAUNCH, WAIT or RESP are ignored. Arbitration happens only in IDLE.
  - Handshake and a pending `REQ` in the same cycle: the request is sampled in the following IDLE cycle, giving one bubble cycle.
  - A requester that drops `REQ` before `GNT` is simply not selected. No error is raised.
  - `RSP_READY` high outside RESP has no effect.
  - `RST_N` low in any state forces IDLE at once, abandons the in-flight result, and sets `rr_ptr`=0.

## Timing
- Reset values:
  - `GNT`=0, `DES_CS_BAR`=1, `DES_ADDRESS`=0, `DES_PLAIN_TEXT`=0.
  - `RSP_VALID`=0, `RSP_ID`=0, `RSP_DATA`=0, `BUSY`=0.
- Request sampled in IDLE at edge t:
  - `GNT` and `DES_CS_BAR`=0 during cycle t..t+1.
  - `RSP_VALID` rises at edge t+1+DES_LATENCY, i.e. edge t+19 with defaults.
- With `RSP_READY` held high, back-to-back throughput is one result per DES_LATENCY+3 cycles (21 with defaults).
- Every output is driven from a register. There is no combinational path from `REQ` or `RSP_READY` to any output.

## Structure
- Package `des_ctrl_pkg` holds:
  - the state enum `des_seq_state_t`;
  - `DES_LATENCY_DEFAULT`=18;
  - `DES_BLOCK_W`=64.
- Sub-module `rr_arbiter`:
  - parameter NREQ;
  - inputs `req`, `ptr`; outputs `gnt_onehot`, `gnt_id`, `any`;
  - purely combinational.
- All registers live in `des_access_sequencer`.

## Test plan
- **Single request:** NREQ=2, `REQ`=2'b01, text 64'h0123456789ABCDEF, `RSP_READY`=1 → `GNT`=01 for 1 cycle, exactly one `DES_CS_BAR` low pulse, `RSP_VALID` 19 cycles after sampling, `RSP_ID`=0, `RSP_DATA` equals the model cipher.
- **Fairness:** `REQ`=2'b11 held for 4 transactions → grant order 0,1,0,1, each 21 cycles apart.
- **Backpressure:** `RSP_READY`=0 for 10 cycles in RESP → `RSP_DATA`/`RSP_ID` stable, `BUSY`=1, no new `GNT`. On release, a 1-cycle handshake, then a return to IDLE.
- **Mid-flight reset:** assert `RST_N`=0 at WAIT cycle 5 → outputs return to reset values asynchronously; after release, `REQ`=2'b10 is granted to requester 1 with `rr_ptr` starting at 0.
- **Non-power-of-2 wrap:** NREQ=3, `REQ`=3'b111 → grants 0,1,2,0; `rr_ptr` never reaches 3.
- **Withdrawn request:** `REQ[1]` pulses for 1 cycle during WAIT and is gone by IDLE → requester 1 is never granted.
